// File: rtl/ram_bus_controller.sv
// ram_bus_controller
//   Turns single requests into timed, strobed cycles on an asynchronous
//   nibble-wide RAM with a shared bidirectional data bus. Each transaction
//   runs IDLE -> SETUP -> PULSE -> HOLD -> IDLE. The state lengths are set
//   by parameters. Completion is reported with a one-cycle rsp_valid pulse
//   in the first IDLE cycle after HOLD.
//
// Parameters
//   SETUP_CYCLES  cycles of address/data setup before the strobe (1..3)
//   PULSE_CYCLES  cycles the strobe is held low                  (1..3)
//   HOLD_CYCLES   cycles of address/data hold after the strobe   (1..3)
//
// Ports
//   clk, nreset        rising-edge clock, asynchronous active-low reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_write          1 = write, 0 = read
//   req_addr/wdata     8-bit address, 4-bit write data
//   rsp_valid/rdata    completion pulse and read data (0 for writes)
//   ram_address        RAM address
//   ram_data_bus       shared RAM data bus (driven only during writes)
//   ram_nwrite_enable  active-low write strobe (registered)
//   ram_nread_enable   active-low read strobe (registered)
module ram_bus_controller #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata,
  output logic [7:0] ram_address,
  inout  wire  [3:0] ram_data_bus,
  output logic       ram_nwrite_enable,
  output logic       ram_nread_enable
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 3) begin : g_bad_setup
    $error("ram_bus_controller: SETUP_CYCLES must be in 1..3");
  end
  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 3) begin : g_bad_pulse
    $error("ram_bus_controller: PULSE_CYCLES must be in 1..3");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 3) begin : g_bad_hold
    $error("ram_bus_controller: HOLD_CYCLES must be in 1..3");
  end

  // The phase counter is loaded with (length - 1) on entry to a state and
  // counts down. A state ends in the cycle in which the counter reads zero.
  localparam logic [1:0] SETUP_LOAD = 2'(SETUP_CYCLES - 1);
  localparam logic [1:0] PULSE_LOAD = 2'(PULSE_CYCLES - 1);
  localparam logic [1:0] HOLD_LOAD  = 2'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t     state_reg, state_next;
  logic [1:0] phase_reg, phase_next;
  logic       write_reg;
  logic [7:0] addr_reg;
  logic [3:0] wdata_reg;
  logic [3:0] sample_reg;
  logic [3:0] rsp_rdata_reg;
  logic       rsp_valid_reg;
  logic       nwe_reg, nre_reg;
  logic       accept, phase_done, bus_oe;

  assign req_ready  = (state_reg == IDLE);
  assign accept     = req_valid && req_ready;
  assign phase_done = (phase_reg == 2'd0);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg - 2'd1;
    case (state_reg)
      IDLE: begin
        phase_next = 2'd0;
        if (accept) begin
          state_next = SETUP;
          phase_next = SETUP_LOAD;
        end
      end
      SETUP: if (phase_done) begin
        state_next = PULSE;
        phase_next = PULSE_LOAD;
      end
      PULSE: if (phase_done) begin
        state_next = HOLD;
        phase_next = HOLD_LOAD;
      end
      HOLD: if (phase_done) begin
        state_next = IDLE;
        phase_next = 2'd0;
      end
      default: begin
        state_next = IDLE;
        phase_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg     <= IDLE;
      phase_reg     <= 2'd0;
      write_reg     <= 1'b0;
      addr_reg      <= 8'd0;
      wdata_reg     <= 4'd0;
      sample_reg    <= 4'd0;
      rsp_rdata_reg <= 4'd0;
      rsp_valid_reg <= 1'b0;
      nwe_reg       <= 1'b1;
      nre_reg       <= 1'b1;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      if (accept) begin
        write_reg <= req_write;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      // The edge that ends the last PULSE cycle captures the RAM's read data.
      if (state_reg == PULSE && phase_done && !write_reg) begin
        sample_reg <= ram_data_bus;
      end
      rsp_valid_reg <= (state_reg == HOLD) && phase_done;
      if (state_reg == HOLD && phase_done) begin
        rsp_rdata_reg <= write_reg ? 4'd0 : sample_reg;
      end
      // Strobes are decoded from the next state so that each is a clean
      // flop output aligned exactly with PULSE. write_reg is stable from
      // acceptance onward, so only one strobe can be low at a time.
      nwe_reg <= !((state_next == PULSE) && write_reg);
      nre_reg <= !((state_next == PULSE) && !write_reg);
    end
  end

  // The bus is driven for the whole write window (SETUP..HOLD). The reset
  // forces state_reg to IDLE, so the bus is released at once by reset.
  assign bus_oe = (state_reg != IDLE) && write_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bus
    assign ram_data_bus[gi] = bus_oe ? wdata_reg[gi] : 1'bz;
  end

  assign ram_address       = addr_reg;
  assign rsp_valid         = rsp_valid_reg;
  assign rsp_rdata         = rsp_rdata_reg;
  assign ram_nwrite_enable = nwe_reg;
  assign ram_nread_enable  = nre_reg;

endmodule
